mem_load_unit: RTL

//  M-stage read-side companion of the store byte-enable logic: executes lw/lh/lhu/lb/lbu.

---
 rtl/mem_load_unit_pkg.sv | 48 ++++
 rtl/mem_load_unit_load_ext.sv | 35 +++
 rtl/mem_load_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - shared MIPS memory opcodes, load op/FSM types and decode helpers
package mem_load_unit_pkg;

  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_LH  = 6'b100001;
  localparam logic [5:0] OPC_LHU = 6'b100101;
  localparam logic [5:0] OPC_LB  = 6'b100000;
  localparam logic [5:0] OPC_LBU = 6'b100100;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_SH  = 6'b101001;
  localparam logic [5:0] OPC_SB  = 6'b101000;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_H    = 3'd2,
    LD_HU   = 3'd3,
    LD_B    = 3'd4,
    LD_BU   = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } ld_state_e;

  function automatic ld_op_e ld_decode(input logic [5:0] opc);
    case (opc)
      OPC_LW:  ld_decode = LD_W;
      OPC_LH:  ld_decode = LD_H;
      OPC_LHU: ld_decode = LD_HU;
      OPC_LB:  ld_decode = LD_B;
      OPC_LBU: ld_decode = LD_BU;
      default: ld_decode = LD_NONE;
    endcase
  endfunction

  // Words need A==00, halves need A[0]==0; bytes are never misaligned.
  function automatic logic ld_misaligned(input ld_op_e op, input logic [1:0] a);
    case (op)
      LD_W:        ld_misaligned = (a != 2'b00);
      LD_H, LD_HU: ld_misaligned = a[0];
      default:     ld_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_load_ext.sv
// rtl/mem_load_unit_load_ext.sv - picks the addressed byte/half of a read word and extends it
module load_ext
  import mem_load_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (a)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h000000, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - M-stage load unit: held bus read, stall/timeout/flush FSM, W-stage result register
module mem_load_unit #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_m,
  input  logic [31:0] addr_m,
  input  logic        flush,
  output logic        bus_rd_req,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        adel,
  output logic        bus_err,
  output logic        ld_valid_w,
  output logic [31:0] ld_data_w
);
  import mem_load_unit_pkg::*;

  ld_state_e       state;
  ld_state_e       state_nx;
  logic [TO_W-1:0] cnt;
  logic [29:0]     addr_q;
  ld_op_e          op_q;
  logic [1:0]      a_q;
  ld_op_e          op_m;
  ld_op_e          ext_op;
  logic [1:0]      ext_a;
  logic [31:0]     ext_result;
  logic            is_load;
  logic            go;
  logic            cnt_hit;
  logic            complete;
  logic            timeout_hit;
  logic            unused_ir;

  assign op_m      = ld_decode(ir_m[31:26]);
  assign is_load   = (op_m != LD_NONE);
  assign adel      = is_load & ld_misaligned(op_m, addr_m[1:0]);
  assign go        = (state == ST_IDLE) & is_load & ~adel & ~flush;
  assign cnt_hit   = (cnt == TO_W'(TIMEOUT - 1));
  assign unused_ir = ^ir_m[25:0];

  load_ext u_ext (
    .op     (ext_op),
    .a      (ext_a),
    .rdata  (bus_rdata),
    .result (ext_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (go && !bus_ack) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (flush)                 state_nx = ST_DRAIN;
        else if (bus_ack || cnt_hit) state_nx = ST_IDLE;
      end
      ST_DRAIN: if (bus_ack || cnt_hit) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Once the load has left IDLE, address and extension come from the latches, not from M.
  always_comb begin
    bus_rd_req  = 1'b0;
    stall       = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    bus_addr    = {addr_m[31:2], 2'b00};
    ext_op      = op_m;
    ext_a       = addr_m[1:0];
    case (state)
      ST_IDLE: begin
        bus_rd_req = go;
        stall      = go & ~bus_ack;
        complete   = go & bus_ack;
      end
      ST_WAIT: begin
        bus_rd_req = 1'b1;
        bus_addr   = {addr_q, 2'b00};
        ext_op     = op_q;
        ext_a      = a_q;
        if (flush)        stall       = 1'b1;
        else if (bus_ack) complete    = 1'b1;
        else if (cnt_hit) timeout_hit = 1'b1;
        else              stall       = 1'b1;
      end
      ST_DRAIN: begin
        bus_rd_req = 1'b1;
        bus_addr   = {addr_q, 2'b00};
        stall      = is_load;
      end
      default: ;
    endcase
    if (reset) begin
      bus_rd_req  = 1'b0;
      stall       = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      addr_q     <= '0;
      op_q       <= LD_NONE;
      a_q        <= 2'b00;
      ld_valid_w <= 1'b0;
      ld_data_w  <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      ld_valid_w <= complete;
      bus_err    <= timeout_hit;
      if (complete) ld_data_w <= ext_result;
      if (go) begin
        addr_q <= addr_m[31:2];
        op_q   <= op_m;
        a_q    <= addr_m[1:0];
        cnt    <= '0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + TO_W'(1);
      end
    end
  end

endmodule
